euler_step_ctrl: RTL
====================

EULER_STEP_CTRL -- requirements
Module: euler_step_ctrl

Interface
REQ-001 Parameter: N_SUB, default 1, Euler substeps per step request (legal 1..15).
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 step  in  1  one-cycle request to advance the state by N_SUB substeps.
REQ-005 deriv  in  32  IEEE-754 single derivative; sampled only in the cycle step is accepted.
REQ-006 init_load  in  1  one-cycle request to overwrite the state with init_val.
REQ-007 init_val  in  32  IEEE-754 single initial state value.
REQ-008 state  out  32  current integrated state, IEEE-754 single.
REQ-009 busy  out  1  high from the cycle after step acceptance until done.
REQ-010 done  out  1  one-cycle pulse at the end of a step.
REQ-011 err_ovf  out  1  sticky; a substep result had exponent 8'hFF (Inf/NaN).
REQ-012 err_drop  out  1  sticky; step arrived while busy.
REQ-013 step_cnt  out  32  completed steps, wraps 32'hFFFFFFFF -> 0.

Function
REQ-014 The FSM SHALL have the states IDLE, CALC, WB and DONE.
REQ-015 IDLE: step=1 and init_load=0 -> latch deriv into deriv_reg, sub_cnt<=0, go to CALC.
REQ-016 CALC: the integrator SHALL be driven with x=deriv_reg and int_x=state; its out SHALL be registered into sum_reg at the end of the cycle; go to WB.
REQ-017 WB: sum_reg[30:23]==8'hFF -> set err_ovf and leave state unchanged; otherwise state<=sum_reg.
REQ-018 WB: sub_cnt<N_SUB-1 -> sub_cnt+1, go to CALC; otherwise go to DONE.
REQ-019 DONE: done=1 for exactly this cycle, step_cnt+1, go to IDLE.
REQ-020 Latency: step sampled at edge k -> done high during the cycle after edge k+2*N_SUB+1.
REQ-021 busy SHALL be 1 in CALC, WB and DONE, and 0 in IDLE.
REQ-022 A step in a non-IDLE state SHALL be dropped, SHALL set err_drop, and SHALL leave deriv_reg unchanged.
REQ-023 init_load in any state SHALL set state<=init_val and go to IDLE with no done pulse and no step_cnt change; a step in the same cycle SHALL be ignored without setting err_drop.
REQ-024 Once err_ovf is set, later substeps SHALL still execute; the flags SHALL clear only on reset.
REQ-025 A derivative underflow (exponent <=10, treated as zero by the integrator) SHALL leave state unchanged and SHALL NOT be flagged.

Reset
REQ-026 reset SHALL force state=0, deriv_reg=0, sum_reg=0, sub_cnt=0, step_cnt=0, FSM=IDLE, and busy, done, err_ovf and err_drop all 0.
REQ-027 Reset mid-step SHALL abort with no done pulse; the first step after deassertion SHALL behave as from power-up.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the constant EXP_INF=8'hFF and the float constants used by benches (F_ONE=32'h3F800000).
REQ-029 The only sub-module SHALL be one instance of integrator (out = x*2^-10 + int_x); all other logic SHALL be local.
REQ-030 sub_cnt SHALL be 4 bits wide; N_SUB>15 SHALL be rejected at elaboration.

Verification
REQ-031 N_SUB=1: init_load with 32'h3F800000, then step with deriv=32'h44800000 -> done after 3 cycles, state=32'h40000000, step_cnt=1.
REQ-032 N_SUB=4: init 1.0, step with deriv=32'h44800000 -> done 9 cycles after step, state=32'h40A00000.
REQ-033 Overflow: init 32'h7F7FFFFF, step with deriv=32'h7F7FFFFF -> err_ovf=1, state stays 32'h7F7FFFFF, done still pulses.
REQ-034 Busy drop: step, then a second step 1 cycle later -> err_drop=1, exactly one done, step_cnt=1.
REQ-035 Abort: step, then reset asserted in CALC -> state=0, busy=0, no done; a following init 1.0 and step with 1024.0 -> state=2.0.
REQ-036 Underflow: state 1.0, step with deriv=32'h05000000 -> state=32'h3F800000, err flags 0, step_cnt+1.

Source files
------------

// File: rtl/euler_step_ctrl_pkg.sv
// Shared types and constants for the Euler step controller.
package euler_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_e;

  // Exponent field value marking Inf/NaN.
  localparam logic [7:0]  EXP_INF   = 8'hFF;
  // The integrator scales the derivative by 2^-10; exponents at or below
  // this value would go subnormal and are treated as zero.
  localparam logic [7:0]  SCALE_EXP = 8'd10;
  localparam logic [31:0] F_ONE     = 32'h3F800000;
  localparam logic [31:0] F_1024    = 32'h44800000;
  localparam logic [31:0] F_QNAN    = 32'h7FC00000;

endpackage

// File: rtl/euler_step_ctrl_if.sv
// Request/status bundle between a host and the Euler step controller.
interface euler_step_ctrl_if;
  import euler_step_ctrl_pkg::*;

  logic        step;
  logic [31:0] deriv;
  logic        init_load;
  logic [31:0] init_val;
  logic [31:0] state;
  logic        busy;
  logic        done;
  logic        err_ovf;
  logic        err_drop;
  logic [31:0] step_cnt;

  modport master (
    output step, deriv, init_load, init_val,
    input  state, busy, done, err_ovf, err_drop, step_cnt
  );

  modport slave (
    input  step, deriv, init_load, init_val,
    output state, busy, done, err_ovf, err_drop, step_cnt
  );

endinterface

// File: rtl/euler_step_ctrl_integrator.sv
// Combinational single-precision integrator: out = x*2^-10 + int_x.
// Round-to-nearest-even; subnormal inputs/results flush to zero; any
// Inf/NaN input or an overflowing sum yields an exponent of 8'hFF.
module integrator
  import euler_step_ctrl_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] int_x,
  output logic [31:0] out
);

  logic [7:0]         xs_e, ix_e, a_e, b_e, d;
  logic [23:0]        xs_m, ix_m, a_m, b_m;
  logic               a_s, b_s, swap, special, lost, rnd;
  logic [50:0]        a_w, b_full, b_sh, b_w;
  logic [51:0]        sum, norm;
  logic [5:0]         lz;
  logic signed [10:0] e_n, e_r;
  logic [23:0]        m_r;

  function automatic logic [5:0] lzc(input logic [51:0] v);
    lzc = 6'd52;
    for (int i = 0; i < 52; i++) begin
      if (v[i]) lzc = 6'(51 - i);
    end
  endfunction

  // Unpack both operands and order them so that |a| >= |b|.
  always_comb begin
    xs_e    = (x[30:23] > SCALE_EXP) ? (x[30:23] - SCALE_EXP) : 8'd0;
    xs_m    = (xs_e == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    ix_e    = int_x[30:23];
    ix_m    = (ix_e == 8'd0) ? 24'd0 : {1'b1, int_x[22:0]};
    special = (x[30:23] == EXP_INF) || (ix_e == EXP_INF);
    swap    = {ix_e, ix_m} > {xs_e, xs_m};
    a_s     = swap ? int_x[31] : x[31];
    a_e     = swap ? ix_e : xs_e;
    a_m     = swap ? ix_m : xs_m;
    b_s     = swap ? x[31] : int_x[31];
    b_e     = swap ? xs_e : ix_e;
    b_m     = swap ? xs_m : ix_m;
  end

  // Align, add/subtract, normalise and round. The 27 extra low bits keep
  // the shifted-out sticky information strictly below the rounding point.
  always_comb begin
    d      = a_e - b_e;
    b_full = {b_m, 27'd0};
    if (d > 8'd50) begin
      b_sh = '0;
      lost = |b_m;
    end else begin
      b_sh = b_full >> d;
      lost = (b_sh << d) != b_full;
    end
    b_w  = b_sh | {50'd0, lost};
    a_w  = {a_m, 27'd0};
    sum  = (a_s == b_s) ? ({1'b0, a_w} + {1'b0, b_w}) : ({1'b0, a_w} - {1'b0, b_w});
    lz   = lzc(sum);
    norm = sum << lz;
    e_n  = $signed({3'b000, a_e}) + 11'sd1 - $signed({5'b00000, lz});
    rnd  = norm[27] & ((|norm[26:0]) | norm[28]);
    m_r  = {1'b0, norm[50:28]} + {23'd0, rnd};
    e_r  = e_n + $signed({10'd0, m_r[23]});
    if (special)              out = F_QNAN;
    else if (!norm[51])       out = 32'd0;
    else if (e_r >= 11'sd255) out = {a_s, EXP_INF, 23'd0};
    else if (e_r <= 11'sd0)   out = 32'd0;
    else                      out = {a_s, e_r[7:0], m_r[22:0]};
  end

endmodule

// File: rtl/euler_step_ctrl.sv
// Euler step controller: each step request runs N_SUB substeps of
// state += deriv*2^-10, writing back only finite results.
module euler_step_ctrl
  import euler_step_ctrl_pkg::*;
#(
  parameter int N_SUB = 1
) (
  input logic              clk,
  input logic              reset,
  euler_step_ctrl_if.slave bus
);

  localparam logic [3:0] LAST_SUB = 4'(N_SUB - 1);

  if (N_SUB < 1 || N_SUB > 15) begin : g_bad_n_sub
    $error("euler_step_ctrl: N_SUB must be in 1..15");
  end

  fsm_state_e  fsm_q, fsm_d;
  logic [31:0] state_q, state_d;
  logic [31:0] deriv_q, deriv_d;
  logic [31:0] sum_q, sum_d;
  logic [3:0]  sub_cnt_q, sub_cnt_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        drop_q, drop_d;
  logic [31:0] integ_out;

  integrator u_integrator (
    .x     (deriv_q),
    .int_x (state_q),
    .out   (integ_out)
  );

  // Next-state logic; init_load overrides everything, including a pending done.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    deriv_d    = deriv_q;
    sum_d      = sum_q;
    sub_cnt_d  = sub_cnt_q;
    step_cnt_d = step_cnt_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    if (bus.init_load) begin
      state_d = bus.init_val;
      fsm_d   = ST_IDLE;
    end else begin
      if (bus.step && fsm_q != ST_IDLE) drop_d = 1'b1;
      unique case (fsm_q)
        ST_IDLE: begin
          if (bus.step) begin
            deriv_d   = bus.deriv;
            sub_cnt_d = 4'd0;
            fsm_d     = ST_CALC;
          end
        end
        ST_CALC: begin
          sum_d = integ_out;
          fsm_d = ST_WB;
        end
        ST_WB: begin
          if (sum_q[30:23] == EXP_INF) ovf_d = 1'b1;
          else                         state_d = sum_q;
          if (sub_cnt_q < LAST_SUB) begin
            sub_cnt_d = sub_cnt_q + 4'd1;
            fsm_d     = ST_CALC;
          end else begin
            fsm_d = ST_DONE;
          end
        end
        ST_DONE: begin
          done_d     = 1'b1;
          step_cnt_d = step_cnt_q + 32'd1;
          fsm_d      = ST_IDLE;
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
    busy_d = (fsm_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q      <= ST_IDLE;
      state_q    <= 32'd0;
      deriv_q    <= 32'd0;
      sum_q      <= 32'd0;
      sub_cnt_q  <= 4'd0;
      step_cnt_q <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      deriv_q    <= deriv_d;
      sum_q      <= sum_d;
      sub_cnt_q  <= sub_cnt_d;
      step_cnt_q <= step_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_ovf  = ovf_q;
  assign bus.err_drop = drop_q;
  assign bus.step_cnt = step_cnt_q;

endmodule
